// File: rtl/comb_sweep_pkg.sv
// Shared types and defaults for the combinational sweep self-test sequencer.
//   state_t             : sequencer state encoding
//   DefaultExpectedMask : golden truth table of the default 3-input block (y=1 at vectors 1 and 4)
package comb_sweep_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSample,
    StDone
  } state_t;

  localparam logic [7:0] DefaultExpectedMask = 8'b0001_0010;

endpackage

// File: rtl/settle_timer.sv
// Settle-time counter for the sweep sequencer.
// Ports:
//   clk_i   : clock
//   reset_i : synchronous active-high reset
//   clr_i   : force count to zero (takes priority over en_i)
//   en_i    : advance count by one
//   tc_o    : terminal count, high while count == SETTLE_CYCLES-1
module settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned Width = $clog2(SETTLE_CYCLES + 1);
  localparam logic [Width-1:0] LastCount = Width'(SETTLE_CYCLES - 1);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign tc_o = (count_q == LastCount);

endmodule

// File: rtl/comb_sweep_ctrl.sv
// Self-test sequencer for a small combinational block. Sweeps all 2**N_IN input vectors,
// holds each for SETTLE_CYCLES cycles, samples y_in and scores it against EXPECTED_MASK.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   start            : level request, only honoured in idle
//   vec_out          : drives the block inputs (MSB = a ... LSB = c)
//   y_in             : block output under test
//   busy / done      : sweep in progress / one-cycle completion pulse
//   pass             : no mismatches, valid from done until the next accepted start
//   err_count        : mismatching vectors, saturates naturally at 2**N_IN (N_IN+1 bits)
//   first_err_valid  : a mismatch has been seen this sweep
//   first_err_idx    : lowest failing vector
//   result_mask      : captured y per vector
module comb_sweep_ctrl
  import comb_sweep_pkg::*;
#(
  parameter int unsigned          N_IN          = 3,
  parameter int unsigned          SETTLE_CYCLES = 4,
  parameter logic [2**N_IN-1:0]   EXPECTED_MASK = DefaultExpectedMask
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [N_IN-1:0]      vec_out,
  input  logic                 y_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        err_count,
  output logic                 first_err_valid,
  output logic [N_IN-1:0]      first_err_idx,
  output logic [2**N_IN-1:0]   result_mask
);

  localparam logic [N_IN-1:0] LastIdx = N_IN'(2**N_IN - 1);

  state_t              state_q;
  logic [N_IN-1:0]     idx_q;
  logic [N_IN-1:0]     vec_q;
  logic                busy_q;
  logic                done_q;
  logic                pass_q;
  logic [N_IN:0]       err_q;
  logic                fev_q;
  logic [N_IN-1:0]     fei_q;
  logic [2**N_IN-1:0]  mask_q;

  logic timer_clr;
  logic timer_en;
  logic timer_tc;
  logic mismatch;

  // Timer is held clear outside SETTLE so every vector starts counting from zero.
  assign timer_clr = (state_q == StIdle) || (state_q == StSample);
  assign timer_en  = (state_q == StSettle);
  assign mismatch  = (y_in != EXPECTED_MASK[idx_q]);

  settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle_timer (
    .clk_i   (clk),
    .reset_i (reset),
    .clr_i   (timer_clr),
    .en_i    (timer_en),
    .tc_o    (timer_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fei_q   <= '0;
      mask_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          vec_q <= '0;
          if (start) begin
            state_q <= StSettle;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fev_q   <= 1'b0;
            fei_q   <= '0;
            mask_q  <= '0;
          end
        end
        StSettle: begin
          if (timer_tc) begin
            state_q <= StSample;
          end
        end
        StSample: begin
          mask_q[idx_q] <= y_in;
          if (mismatch) begin
            err_q <= err_q + 1'b1;
            if (!fev_q) begin
              fev_q <= 1'b1;
              fei_q <= idx_q;
            end
          end
          // Explicit last-vector compare keeps idx_q from wrapping back to zero.
          if (idx_q == LastIdx) begin
            state_q <= StDone;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            pass_q  <= (err_q == '0) && !mismatch;
          end else begin
            idx_q   <= idx_q + 1'b1;
            vec_q   <= idx_q + 1'b1;
            state_q <= StSettle;
          end
        end
        StDone: begin
          state_q <= StIdle;
          vec_q   <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign vec_out         = vec_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_valid = fev_q;
  assign first_err_idx   = fei_q;
  assign result_mask     = mask_q;

endmodule
